// File: rtl/soundweb_pkg.sv
// Shared Soundweb protocol constants: reserved bytes, payload layout, error codes.
// Used by both the packet encoder and the receive decoder.
package soundweb_pkg;

  localparam logic [7:0] STX = 8'h02;
  localparam logic [7:0] ETX = 8'h03;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam logic [7:0] ESC = 8'h1B;

  localparam int unsigned IDX_COMMAND   = 0;
  localparam int unsigned IDX_ADDRESS_0 = 1;
  localparam int unsigned IDX_SV_0      = 7;
  localparam int unsigned IDX_DATA_0    = 9;
  localparam int unsigned IDX_CHECKSUM  = 13;
  localparam int unsigned PAYLOAD_BYTES = 13;
  localparam int unsigned FRAME_BYTES   = 14;

  localparam logic [2:0] ERR_CHECKSUM   = 3'd0;
  localparam logic [2:0] ERR_LENGTH     = 3'd1;
  localparam logic [2:0] ERR_ESCAPE     = 3'd2;
  localparam logic [2:0] ERR_UNEXPECTED = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT    = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StBody,
    StEscaped
  } rx_state_e;

  function automatic logic is_reserved_byte(input logic [7:0] b);
    return (b == STX) || (b == ETX) || (b == ACK) || (b == NAK) || (b == ESC);
  endfunction

endpackage

// File: rtl/soundweb_rx_decoder.sv
// Soundweb receive decoder: frames STX/ETX, un-escapes, checks XOR checksum and
// presents the 13 decoded payload bytes with one-cycle valid/error pulses.
module soundweb_rx_decoder
  import soundweb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] command,
  output logic [7:0] address_0,
  output logic [7:0] address_1,
  output logic [7:0] address_2,
  output logic [7:0] address_3,
  output logic [7:0] address_4,
  output logic [7:0] address_5,
  output logic [7:0] sv_0,
  output logic [7:0] sv_1,
  output logic [7:0] data_0,
  output logic [7:0] data_1,
  output logic [7:0] data_2,
  output logic [7:0] data_3,
  output logic       frame_valid,
  output logic       frame_error,
  output logic [2:0] error_code,
  output logic       ack_rx,
  output logic       nak_rx
);

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  FULL     = 4'(FRAME_BYTES);

  rx_state_e   r_state;
  logic [3:0]  r_count;
  logic [7:0]  r_xor;
  logic [15:0] r_to_cnt;
  logic [7:0]  r_shadow [FRAME_BYTES];
  logic [7:0]  r_field  [PAYLOAD_BYTES];
  logic        r_frame_valid;
  logic        r_frame_error;
  logic [2:0]  r_error_code;
  logic        r_ack_rx;
  logic        r_nak_rx;

  logic [7:0]  w_unesc;
  logic [7:0]  w_store_byte;
  logic        w_store;
  logic        w_timeout;

  assign w_unesc = rx_data - 8'h80;

  // A byte is stored when it is plain data in BODY or a legal escaped value.
  always_comb begin
    w_store_byte = (r_state == StEscaped) ? w_unesc : rx_data;
    w_store      = 1'b0;
    if (rx_valid) begin
      case (r_state)
        StBody:    w_store = !is_reserved_byte(rx_data);
        StEscaped: w_store = is_reserved_byte(w_unesc);
        default:   w_store = 1'b0;
      endcase
    end
  end

  assign w_timeout = (TIMEOUT_CYCLES != 0) && !rx_valid && (r_state != StIdle) &&
                     (r_to_cnt == TO_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_count       <= '0;
      r_xor         <= '0;
      r_to_cnt      <= '0;
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
      r_error_code  <= '0;
      r_ack_rx      <= 1'b0;
      r_nak_rx      <= 1'b0;
      for (int i = 0; i < FRAME_BYTES; i++) r_shadow[i] <= '0;
      for (int i = 0; i < PAYLOAD_BYTES; i++) r_field[i] <= '0;
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
      r_ack_rx      <= 1'b0;
      r_nak_rx      <= 1'b0;

      if (rx_valid || (r_state == StIdle)) r_to_cnt <= '0;
      else                                 r_to_cnt <= r_to_cnt + 16'd1;

      if (w_timeout) begin
        r_frame_error <= 1'b1;
        r_error_code  <= ERR_TIMEOUT;
        r_state       <= StIdle;
        r_to_cnt      <= '0;
      end else if (w_store) begin
        if (r_count == FULL) begin
          r_frame_error <= 1'b1;
          r_error_code  <= ERR_LENGTH;
          r_state       <= StIdle;
        end else begin
          r_shadow[r_count] <= w_store_byte;
          r_xor             <= r_xor ^ w_store_byte;
          r_count           <= r_count + 4'd1;
          r_state           <= StBody;
        end
      end else if (rx_valid) begin
        case (r_state)
          StIdle: begin
            if (rx_data == STX) begin
              r_state <= StBody;
              r_count <= '0;
              r_xor   <= '0;
            end else if (rx_data == ACK) begin
              r_ack_rx <= 1'b1;
            end else if (rx_data == NAK) begin
              r_nak_rx <= 1'b1;
            end
          end
          StBody: begin
            // Only reserved bytes reach here; plain data took the store path.
            if (rx_data == ESC) begin
              r_state <= StEscaped;
            end else if (rx_data == ETX) begin
              r_state <= StIdle;
              if ((r_count == FULL) && (r_xor == 8'h00)) begin
                r_frame_valid <= 1'b1;
                for (int i = 0; i < PAYLOAD_BYTES; i++) r_field[i] <= r_shadow[i];
              end else begin
                r_frame_error <= 1'b1;
                r_error_code  <= (r_count == FULL) ? ERR_CHECKSUM : ERR_LENGTH;
              end
            end else if (rx_data == STX) begin
              r_frame_error <= 1'b1;
              r_error_code  <= ERR_UNEXPECTED;
              r_count       <= '0;
              r_xor         <= '0;
            end else begin
              r_frame_error <= 1'b1;
              r_error_code  <= ERR_UNEXPECTED;
              r_state       <= StIdle;
            end
          end
          StEscaped: begin
            r_frame_error <= 1'b1;
            r_error_code  <= ERR_ESCAPE;
            r_state       <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign command     = r_field[IDX_COMMAND];
  assign address_0   = r_field[IDX_ADDRESS_0];
  assign address_1   = r_field[IDX_ADDRESS_0 + 1];
  assign address_2   = r_field[IDX_ADDRESS_0 + 2];
  assign address_3   = r_field[IDX_ADDRESS_0 + 3];
  assign address_4   = r_field[IDX_ADDRESS_0 + 4];
  assign address_5   = r_field[IDX_ADDRESS_0 + 5];
  assign sv_0        = r_field[IDX_SV_0];
  assign sv_1        = r_field[IDX_SV_0 + 1];
  assign data_0      = r_field[IDX_DATA_0];
  assign data_1      = r_field[IDX_DATA_0 + 1];
  assign data_2      = r_field[IDX_DATA_0 + 2];
  assign data_3      = r_field[IDX_DATA_0 + 3];
  assign frame_valid = r_frame_valid;
  assign frame_error = r_frame_error;
  assign error_code  = r_error_code;
  assign ack_rx      = r_ack_rx;
  assign nak_rx      = r_nak_rx;

endmodule

// File: tb/tb_soundweb_rx_decoder.sv
// Bench for soundweb_rx_decoder: directed vector table, hand sequences and random
// frames, all compared cycle by cycle against a byte-queue protocol model.
module tb_soundweb_rx_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] command, address_0, address_1, address_2, address_3, address_4, address_5;
  logic [7:0] sv_0, sv_1, data_0, data_1, data_2, data_3;
  logic       frame_valid, frame_error, ack_rx, nak_rx;
  logic [2:0] error_code;

  always #5 clk = ~clk;

  soundweb_rx_decoder #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .command(command), .address_0(address_0), .address_1(address_1),
    .address_2(address_2), .address_3(address_3), .address_4(address_4),
    .address_5(address_5), .sv_0(sv_0), .sv_1(sv_1), .data_0(data_0),
    .data_1(data_1), .data_2(data_2), .data_3(data_3),
    .frame_valid(frame_valid), .frame_error(frame_error), .error_code(error_code),
    .ack_rx(ack_rx), .nak_rx(nak_rx)
  );

  int checks = 0;
  int errors = 0;

  // Protocol model: a frame is a queue of payload bytes, validated at ETX.
  bit         m_in_frame = 0;
  bit         m_esc = 0;
  int         m_idle = 0;
  logic [7:0] m_q[$];
  logic [7:0] m_fields [13];
  bit         e_fv, e_fe, e_ack, e_nak;
  logic [2:0] e_code;

  int         n_fv = 0, n_fe = 0, n_ack = 0, n_nak = 0;
  logic [2:0] last_code = 3'd7;

  typedef struct {
    string      name;
    int         len;
    logic [7:0] s [24];
    int         exp_fv;
    int         exp_fe;
    logic [2:0] exp_code;
    int         exp_ack;
    int         exp_nak;
    logic [7:0] exp_cmd;
    logic [7:0] exp_d3;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] gold[$] = '{8'h02, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                          8'h01, 8'h00, 8'h00, 8'h00, 8'h05, 8'h8C, 8'h03};

  function automatic bit reserved(input logic [7:0] b);
    return b inside {8'h02, 8'h03, 8'h06, 8'h15, 8'h1B};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_in_frame = 0;
    m_esc      = 0;
    m_idle     = 0;
    m_q.delete();
    for (int i = 0; i < 13; i++) m_fields[i] = 8'h00;
    e_fv = 0; e_fe = 0; e_ack = 0; e_nak = 0; e_code = 3'd0;
  endtask

  task automatic model_err(input logic [2:0] code);
    e_fe       = 1;
    e_code     = code;
    m_in_frame = 0;
    m_esc      = 0;
  endtask

  task automatic model_push(input logic [7:0] b);
    if (m_q.size() == 14) model_err(3'd1);
    else m_q.push_back(b);
  endtask

  task automatic model_step(input bit v, input logic [7:0] b);
    logic [7:0] x;
    e_fv = 0; e_fe = 0; e_ack = 0; e_nak = 0;
    if (!v) begin
      if (m_in_frame) begin
        m_idle++;
        if (m_idle == 8) model_err(3'd4);
      end
      return;
    end
    m_idle = 0;
    if (!m_in_frame) begin
      if (b == 8'h02) begin
        m_in_frame = 1;
        m_esc      = 0;
        m_q.delete();
      end else if (b == 8'h06) e_ack = 1;
      else if (b == 8'h15) e_nak = 1;
    end else if (m_esc) begin
      m_esc = 0;
      x = b - 8'h80;
      if (reserved(x)) model_push(x);
      else model_err(3'd2);
    end else begin
      case (b)
        8'h1B: m_esc = 1;
        8'h03: begin
          x = 8'h00;
          foreach (m_q[i]) x ^= m_q[i];
          if (m_q.size() != 14) model_err(3'd1);
          else if (x != 8'h00) model_err(3'd0);
          else begin
            e_fv = 1;
            m_in_frame = 0;
            for (int i = 0; i < 13; i++) m_fields[i] = m_q[i];
          end
        end
        8'h02: begin
          e_fe   = 1;
          e_code = 3'd3;
          m_q.delete();
        end
        8'h06, 8'h15: model_err(3'd3);
        default: model_push(b);
      endcase
    end
  endtask

  task automatic compare_outputs();
    logic [103:0] act_f, exp_f;
    act_f = {command, address_0, address_1, address_2, address_3, address_4, address_5,
             sv_0, sv_1, data_0, data_1, data_2, data_3};
    for (int i = 0; i < 13; i++) exp_f[103 - 8*i -: 8] = m_fields[i];
    check("pulses{fv,fe,ack,nak}", 128'({frame_valid, frame_error, ack_rx, nak_rx}),
          128'({e_fv, e_fe, e_ack, e_nak}));
    if (e_fe) check("error_code", 128'(error_code), 128'(e_code));
    check("fields", 128'(act_f), 128'(exp_f));
    n_fv  += int'(frame_valid);
    n_fe  += int'(frame_error);
    n_ack += int'(ack_rx);
    n_nak += int'(nak_rx);
    if (frame_error) last_code = error_code;
  endtask

  task automatic step(input bit v, input logic [7:0] b);
    @(negedge clk);
    compare_outputs();
    model_step(v, b);
    rx_valid = v;
    rx_data  = v ? b : 8'($urandom);
  endtask

  task automatic send(input logic [7:0] s[$]);
    foreach (s[i]) step(1'b1, s[i]);
  endtask

  task automatic set_vec(input int idx, input string name, input logic [7:0] s[$],
                         input int fv, input int fe, input logic [2:0] code,
                         input int ack, input int nak, input logic [7:0] cmd,
                         input logic [7:0] d3);
    vecs[idx].name = name;
    vecs[idx].len  = s.size();
    for (int i = 0; i < 24; i++) vecs[idx].s[i] = (i < s.size()) ? s[i] : 8'h00;
    vecs[idx].exp_fv   = fv;
    vecs[idx].exp_fe   = fe;
    vecs[idx].exp_code = code;
    vecs[idx].exp_ack  = ack;
    vecs[idx].exp_nak  = nak;
    vecs[idx].exp_cmd  = cmd;
    vecs[idx].exp_d3   = d3;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tmp[$];
    logic [7:0] pl[$];
    logic [7:0] enc[$];
    logic [7:0] cks;
    int b0, b1, b2, b3, r, pos;

    model_clear();

    // Directed vector table
    set_vec(0, "golden", gold, 1, 0, 3'd0, 0, 0, 8'h88, 8'h05);
    tmp = gold; tmp[13] = 8'h1B; tmp.insert(14, 8'h83); tmp[15] = 8'h8A;
    set_vec(1, "escaped", tmp, 1, 0, 3'd0, 0, 0, 8'h88, 8'h03);
    tmp = gold; tmp[14] = 8'h8D;
    set_vec(2, "bad_cksum", tmp, 0, 1, 3'd0, 0, 0, 8'h00, 8'h00);
    tmp = gold; tmp.delete(2);
    set_vec(3, "short", tmp, 0, 1, 3'd1, 0, 0, 8'h00, 8'h00);
    tmp = gold; tmp.insert(2, 8'h00);
    set_vec(4, "long", tmp, 0, 1, 3'd1, 0, 0, 8'h00, 8'h00);
    tmp = gold; tmp.insert(2, 8'h1B); tmp.insert(3, 8'h41);
    set_vec(5, "bad_escape", tmp, 0, 1, 3'd2, 0, 0, 8'h00, 8'h00);
    tmp = '{8'h06, 8'h15};
    set_vec(6, "ack_nak", tmp, 0, 0, 3'd0, 1, 1, 8'h00, 8'h00);
    tmp = '{8'h02, 8'h88, 8'h00};
    foreach (gold[i]) tmp.push_back(gold[i]);
    set_vec(7, "stx_restart", tmp, 1, 1, 3'd3, 0, 0, 8'h88, 8'h05);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pulses", 128'({frame_valid, frame_error, ack_rx, nak_rx, error_code}), 128'd0);
    check("reset_fields", 128'({command, sv_1, data_3}), 128'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      b0 = n_fv; b1 = n_fe; b2 = n_ack; b3 = n_nak;
      for (int j = 0; j < vecs[v].len; j++) step(1'b1, vecs[v].s[j]);
      step(1'b0, 8'h00);
      step(1'b0, 8'h00);
      check($sformatf("%s_fv_count", vecs[v].name), 128'(n_fv - b0), 128'(vecs[v].exp_fv));
      check($sformatf("%s_fe_count", vecs[v].name), 128'(n_fe - b1), 128'(vecs[v].exp_fe));
      check($sformatf("%s_ack_count", vecs[v].name), 128'(n_ack - b2), 128'(vecs[v].exp_ack));
      check($sformatf("%s_nak_count", vecs[v].name), 128'(n_nak - b3), 128'(vecs[v].exp_nak));
      if (vecs[v].exp_fe > 0)
        check($sformatf("%s_code", vecs[v].name), 128'(last_code), 128'(vecs[v].exp_code));
      if (vecs[v].exp_fv > 0) begin
        check($sformatf("%s_cmd", vecs[v].name), 128'(command), 128'(vecs[v].exp_cmd));
        check($sformatf("%s_data3", vecs[v].name), 128'(data_3), 128'(vecs[v].exp_d3));
      end
    end

    // Timeout: 8 idle cycles inside a frame aborts, 7 does not
    b1 = n_fe;
    send('{8'h02, 8'h88});
    repeat (8) step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    check("timeout_fe_count", 128'(n_fe - b1), 128'd1);
    check("timeout_code", 128'(last_code), 128'd4);
    b0 = n_fv;
    send('{8'h02, 8'h88});
    repeat (7) step(1'b0, 8'h00);
    tmp = gold; tmp.delete(0); tmp.delete(0);
    send(tmp);
    step(1'b0, 8'h00);
    check("stall7_fv_count", 128'(n_fv - b0), 128'd1);

    // Asynchronous reset mid-frame: no pulse, model and DUT both cleared
    send('{8'h02, 8'h11, 8'h22, 8'h33});
    @(negedge clk);
    compare_outputs();
    rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    model_clear();
    #5;
    check("midreset_outputs", 128'({frame_valid, frame_error, command, data_3}), 128'd0);
    #5 rst_n = 1'b1;
    b0 = n_fv; b1 = n_fe;
    send(gold);
    step(1'b0, 8'h00);
    check("post_reset_fv_count", 128'(n_fv - b0), 128'd1);
    check("post_reset_fe_count", 128'(n_fe - b1), 128'd0);
    check("post_reset_cmd", 128'(command), 128'h88);

    // Random frames with occasional corruption, all judged by the model
    for (int f = 0; f < 150; f++) begin
      pl.delete();
      cks = 8'h00;
      for (int i = 0; i < 13; i++) begin
        r = $urandom_range(0, 3);
        if (r == 0) begin
          tmp = '{8'h02, 8'h03, 8'h06, 8'h15, 8'h1B};
          pl.push_back(tmp[$urandom_range(0, 4)]);
        end else pl.push_back(8'($urandom));
        cks ^= pl[i];
      end
      pl.push_back(cks);
      r = $urandom_range(0, 11);
      if (r == 0) pl[13] = pl[13] ^ 8'(1 << $urandom_range(0, 7));
      else if (r == 1) pl.delete($urandom_range(0, 13));
      else if (r == 2) pl.insert($urandom_range(0, 13), 8'($urandom));
      enc.delete();
      enc.push_back(8'h02);
      foreach (pl[i]) begin
        if (reserved(pl[i])) begin
          enc.push_back(8'h1B);
          enc.push_back(pl[i] + 8'h80);
        end else enc.push_back(pl[i]);
      end
      enc.push_back(8'h03);
      pos = $urandom_range(1, enc.size() - 2);
      if (r == 3) begin
        enc.insert(pos, 8'h41);
        enc.insert(pos, 8'h1B);
      end else if (r == 4) enc.insert(pos, 8'h06);
      else if (r == 5) enc.insert(pos, 8'h02);
      for (int i = 0; i < enc.size(); i++) begin
        if (r == 6 && i == pos) repeat ($urandom_range(7, 9)) step(1'b0, 8'h00);
        else repeat ($urandom_range(0, 2)) step(1'b0, 8'h00);
        step(1'b1, enc[i]);
      end
      if ($urandom_range(0, 3) == 0) begin
        tmp = '{8'h06, 8'h15, 8'h03, 8'h5A};
        step(1'b1, tmp[$urandom_range(0, 3)]);
      end
    end

    repeat (3) step(1'b0, 8'h00);
    check("random_saw_frames", 128'(n_fv > 20), 128'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
